// File: rtl/text_line_reader.sv
// -----------------------------------------------------------------------------
// text_line_reader
//
// Scans one frame of a character-cell text RAM and streams the cells out in
// display order (line 0..ROWS-1, column 0..COLUMNS-1). The RAM is read one
// whole line at a time. The scan may start at any physical RAM row, which lets
// the frame scroll. The physical row wraps back to 0 after ROWS-1.
//
// Ports
//   clk          rising-edge clock for all logic
//   rst          synchronous, active-high reset
//   start        one-cycle pulse that begins a frame scan (ignored while busy)
//   first_row    physical RAM row shown as display line 0; sampled with start
//   ram_address  text RAM line address; held between line requests
//   ram_wren     text RAM write enable; always 0 (read-only client)
//   ram_data     text RAM write data; always 0
//   ram_q        text RAM read line; cell i is ram_q[CHAR_WIDTH*i +: CHAR_WIDTH]
//   char_valid   a cell is presented downstream
//   char_ready   downstream accepts the presented cell
//   char_data    presented cell
//   char_row     display line of the presented cell
//   char_col     column of the presented cell
//   char_last    presented cell is the final one of the frame
//   busy         a frame scan is in progress
//   done         one-cycle pulse after the final cell has been transferred
//   dbg_state    current FSM state, for observation only
//
// Handshake (char_*): a cell moves on every rising edge where char_valid and
// char_ready are both 1. Once char_valid is raised it stays high, and
// char_data/char_row/char_col/char_last hold their values until that transfer
// happens. char_valid never depends on char_ready.
// -----------------------------------------------------------------------------
module text_line_reader #(
    parameter int COLUMNS      = 80,
    parameter int ROWS         = 50,
    parameter int CHAR_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [7:0]                    first_row,
    output logic [7:0]                    ram_address,
    output logic                          ram_wren,
    output logic [COLUMNS*CHAR_WIDTH-1:0] ram_data,
    input  logic [COLUMNS*CHAR_WIDTH-1:0] ram_q,
    output logic                          char_valid,
    input  logic                          char_ready,
    output logic [CHAR_WIDTH-1:0]         char_data,
    output logic [7:0]                    char_row,
    output logic [7:0]                    char_col,
    output logic                          char_last,
    output logic                          busy,
    output logic                          done,
    output logic [2:0]                    dbg_state
);

    localparam int COL_W  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int WAIT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        LATCH = 3'd3,
        EMIT  = 3'd4
    } state_t;

    // Physical row for a display line. The sum is at most 2*(ROWS-1), so one
    // conditional subtraction is enough to wrap it back into 0..ROWS-1.
    function automatic logic [7:0] wrap_row(input logic [7:0] base,
                                            input logic [7:0] line);
        logic [8:0] sum;
        sum = {1'b0, base} + {1'b0, line};
        if (sum >= 9'(ROWS)) begin
            sum = sum - 9'(ROWS);
        end
        return 8'(sum);
    endfunction

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [7:0]          base_q, base_d;     // scroll offset, always < ROWS
    logic [7:0]          line_q, line_d;     // display line index
    logic [COL_W-1:0]    col_q, col_d;       // column index within the line
    logic [WAIT_W-1:0]   wait_q, wait_d;     // RAM latency counter
    logic [7:0]          addr_q, addr_d;     // registered RAM line address
    logic                done_q, done_d;
    logic                latch_en;           // copy ram_q into the line buffer

    logic [CHAR_WIDTH-1:0] line_buf_q [COLUMNS];

    logic       is_last_col;
    logic       is_last_line;
    logic [7:0] start_base;
    logic [7:0] next_line;

    assign is_last_col  = (col_q == COL_W'(COLUMNS - 1));
    assign is_last_line = (line_q == 8'(ROWS - 1));
    assign next_line    = line_q + 8'd1;

    // Out-of-range scroll offsets fall back to the top of the text RAM.
    assign start_base = (first_row >= 8'(ROWS)) ? 8'd0 : first_row;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        line_d   = line_q;
        col_d    = col_q;
        wait_d   = wait_q;
        addr_d   = addr_q;
        done_d   = 1'b0;
        latch_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = start_base;
                    line_d  = 8'd0;
                    col_d   = '0;
                    // The address is registered on the way into REQ so it is
                    // already stable on the RAM port during the REQ cycle.
                    addr_d  = wrap_row(start_base, 8'd0);
                    state_d = REQ;
                end
            end

            REQ: begin
                wait_d  = '0;
                // With a single-cycle RAM the data is ready straight after REQ.
                state_d = (READ_LATENCY > 1) ? WAIT : LATCH;
            end

            WAIT: begin
                // Spends READ_LATENCY-1 cycles here; LATCH then lands exactly
                // READ_LATENCY cycles after the REQ cycle.
                if (wait_q == WAIT_W'(READ_LATENCY - 2)) begin
                    state_d = LATCH;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            LATCH: begin
                latch_en = 1'b1;
                state_d  = EMIT;
            end

            EMIT: begin
                if (char_ready) begin
                    if (!is_last_col) begin
                        col_d = col_q + 1'b1;
                    end else if (!is_last_line) begin
                        col_d   = '0;
                        line_d  = next_line;
                        addr_d  = wrap_row(base_q, next_line);
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= 8'd0;
            line_q  <= 8'd0;
            col_q   <= '0;
            wait_q  <= '0;
            addr_q  <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            line_q  <= line_d;
            col_q   <= col_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    // Line buffer: pure datapath, so it is not reset. Its contents are only
    // visible through char_data while in EMIT, which always follows a LATCH.
    always_ff @(posedge clk) begin
        if (latch_en && !rst) begin
            for (int i = 0; i < COLUMNS; i++) begin
                line_buf_q[i] <= ram_q[CHAR_WIDTH*i +: CHAR_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Presentation outputs are forced to zero outside EMIT, which also gives
    // the all-zero values required while in reset and idle.
    assign char_valid  = (state_q == EMIT);
    assign char_data   = char_valid ? line_buf_q[col_q] : '0;
    assign char_row    = char_valid ? line_q : 8'd0;
    assign char_col    = char_valid ? 8'(col_q) : 8'd0;
    assign char_last   = char_valid && is_last_col && is_last_line;

    assign busy        = (state_q != IDLE);
    assign done        = done_q;

    assign ram_address = addr_q;
    assign ram_wren    = 1'b0;
    assign ram_data    = '0;

    assign dbg_state   = state_q;

endmodule

// File: tb/tb_text_line_reader.sv
// -----------------------------------------------------------------------------
// tb_text_line_reader
//
// Drives text_line_reader against a line-wide RAM model with two cycles of
// read latency. A reference model builds the whole expected frame as a queue
// of (line, column, cell, last, physical row) from the scroll offset and the
// RAM contents. One negedge process compares every transfer, the hold-during-
// stall behaviour, busy/done, the line-to-line gap and the reset values.
// -----------------------------------------------------------------------------
module tb_text_line_reader;

    localparam int COLUMNS = 80;
    localparam int ROWS    = 50;
    localparam int CW      = 32;
    localparam int LAT     = 2;
    localparam int CELLS   = COLUMNS * ROWS;

    // ------------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic                    start;
    logic [7:0]              first_row;
    logic [7:0]              ram_address;
    logic                    ram_wren;
    logic [COLUMNS*CW-1:0]   ram_data;
    logic [COLUMNS*CW-1:0]   ram_q;
    logic                    char_valid;
    logic                    char_ready;
    logic [CW-1:0]           char_data;
    logic [7:0]              char_row;
    logic [7:0]              char_col;
    logic                    char_last;
    logic                    busy;
    logic                    done;
    logic [2:0]              dbg_state;

    text_line_reader #(
        .COLUMNS      (COLUMNS),
        .ROWS         (ROWS),
        .CHAR_WIDTH   (CW),
        .READ_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .first_row   (first_row),
        .ram_address (ram_address),
        .ram_wren    (ram_wren),
        .ram_data    (ram_data),
        .ram_q       (ram_q),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .char_data   (char_data),
        .char_row    (char_row),
        .char_col    (char_col),
        .char_last   (char_last),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // ------------------------------------------------------------------------
    // Text RAM model: address register, then data register (2-cycle latency)
    // ------------------------------------------------------------------------
    logic [CW-1:0] mem [ROWS][COLUMNS];
    logic [7:0]    ram_a1;

    always @(posedge clk) begin
        int ai;
        ram_a1 <= ram_address;
        ai = int'(ram_a1);
        for (int i = 0; i < COLUMNS; i++) begin
            if (ai < ROWS) ram_q[CW*i +: CW] <= mem[ai][i];
            else           ram_q[CW*i +: CW] <= 32'hBAD0_0000;
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [7:0]    row;
        logic [7:0]    col;
        logic [CW-1:0] data;
        logic          last;
        logic [7:0]    phys;
    } cell_t;

    cell_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    int obs_addr [ROWS];

    bit checking = 1'b0;
    int ready_pct = 100;

    bit          m_busy        = 1'b0;
    bit          m_done_next   = 1'b0;
    bit          m_after_reset = 1'b1;
    bit          stall_pend    = 1'b0;
    bit          gap_active    = 1'b0;
    int          gap_cnt       = 0;
    bit          was_busy;
    logic [48:0] cur;
    logic [48:0] held;
    cell_t       e;
    int          m_base;
    int          m_phys;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame: display line ln comes from physical row (base+ln) mod ROWS.
    task automatic build_frame(input logic [7:0] fr);
        exp_q.delete();
        m_base = (int'(fr) >= ROWS) ? 0 : int'(fr);
        for (int ln = 0; ln < ROWS; ln++) begin
            m_phys = (m_base + ln) % ROWS;
            obs_addr[ln] = 255;
            for (int c = 0; c < COLUMNS; c++) begin
                e.row  = 8'(ln);
                e.col  = 8'(c);
                e.data = mem[m_phys][c];
                e.last = (ln == ROWS - 1) && (c == COLUMNS - 1);
                e.phys = 8'(m_phys);
                exp_q.push_back(e);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Compare process: outputs sampled mid-cycle, inputs already stable
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (checking) begin
            cur = {char_row, char_col, char_data, char_last};

            check("ram_write_idle", 64'(ram_wren | (|ram_data)), 64'd0);
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done_next));
            if (!m_busy) check("idle_no_valid", 64'(char_valid), 64'd0);
            if (m_after_reset)
                check("reset_outputs",
                      64'({char_valid, char_last, busy, done, ram_address, char_data, char_row, char_col}),
                      64'd0);
            if (stall_pend) check("stall_hold", 64'({char_valid, cur}), 64'({1'b1, held}));

            if (rst) begin
                m_busy        = 1'b0;
                m_done_next   = 1'b0;
                m_after_reset = 1'b1;
                stall_pend    = 1'b0;
                gap_active    = 1'b0;
                exp_q.delete();
            end else begin
                m_after_reset = 1'b0;
                m_done_next   = 1'b0;
                was_busy      = m_busy;

                if (gap_active) begin
                    if (char_valid) begin
                        check("line_gap", 64'(gap_cnt), 64'(LAT + 1));
                        gap_active = 1'b0;
                    end else if (gap_cnt > 50) begin
                        check("line_gap_timeout", 64'(gap_cnt), 64'(LAT + 1));
                        gap_active = 1'b0;
                    end else begin
                        gap_cnt++;
                    end
                end

                stall_pend = char_valid && !char_ready;
                held       = cur;

                if (char_valid && char_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_transfer: got row %0d col %0d, expected no transfer",
                                 char_row, char_col);
                    end else begin
                        e = exp_q.pop_front();
                        check("cell", 64'(cur), 64'({e.row, e.col, e.data, e.last}));
                        if (e.col == 8'd0) begin
                            check("line_address", 64'(ram_address), 64'(e.phys));
                            obs_addr[int'(e.row)] = int'(ram_address);
                        end
                        n_xfer++;
                        if (int'(e.col) == COLUMNS - 1 && !e.last) begin
                            gap_active = 1'b1;
                            gap_cnt    = 0;
                        end
                        if (e.last) begin
                            m_busy      = 1'b0;
                            m_done_next = 1'b1;
                        end
                    end
                end

                if (start && !was_busy) begin
                    build_frame(first_row);
                    m_busy = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] fr);
        tick();
        first_row = fr;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] fr);
        first_row = fr;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    // Downstream ready: drawn each cycle with probability ready_pct percent.
    initial begin
        char_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            char_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < 32'(ready_pct));
        end
    end

    // Watchdog
    initial begin
        #10_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int x0;
        bit hit;

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLUMNS; c++)
                mem[r][c] = $urandom;

        rst       = 1'b1;
        start     = 1'b0;
        first_row = 8'd0;
        tick();
        tick();
        checking = 1'b1;
        tick();
        rst = 1'b0;

        // Straight frame from row 0, no back-pressure.
        x0 = n_xfer;
        start_frame(8'd0);
        check("s1_model_phys0", 64'(exp_q[0].phys), 64'd0);
        wait_done(6000, "s1");
        check("s1_count", 64'(n_xfer - x0), 64'(CELLS));
        check("s1_addr_line0", 64'(obs_addr[0]), 64'd0);
        check("s1_addr_line49", 64'(obs_addr[49]), 64'd49);

        // Scroll offset 48: physical rows 48, 49, 0, 1, ... 47.
        x0 = n_xfer;
        start_frame(8'd48);
        check("s2_model_phys0", 64'(exp_q[0].phys), 64'd48);
        check("s2_model_phys2", 64'(exp_q[2*COLUMNS].phys), 64'd0);
        wait_done(6000, "s2");
        check("s2_count", 64'(n_xfer - x0), 64'(CELLS));
        check("s2_addr_line0", 64'(obs_addr[0]), 64'd48);
        check("s2_addr_line1", 64'(obs_addr[1]), 64'd49);
        check("s2_addr_line2", 64'(obs_addr[2]), 64'd0);
        check("s2_addr_line49", 64'(obs_addr[49]), 64'd47);

        // Random offset with 50% back-pressure.
        ready_pct = 50;
        x0 = n_xfer;
        start_frame(8'($urandom_range(ROWS - 1)));
        wait_done(20000, "s3");
        check("s3_count", 64'(n_xfer - x0), 64'(CELLS));

        // start pulses mid-frame must be ignored.
        ready_pct = 80;
        x0 = n_xfer;
        start_frame(8'd7);
        repeat (500) tick();
        pulse_start(8'd30);
        repeat (900) tick();
        pulse_start(8'd0);
        wait_done(15000, "s4");
        check("s4_count", 64'(n_xfer - x0), 64'(CELLS));

        // Reset while line 10, column 5 is presented.
        ready_pct = 100;
        start_frame(8'd0);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (char_valid && char_row == 8'd10 && char_col == 8'd5) begin
                hit = 1'b1;
                break;
            end
        end
        check("s5_reached_10_5", 64'(hit), 64'd1);
        rst = 1'b1;
        tick();
        check("s5_valid_after_rst", 64'(char_valid), 64'd0);
        check("s5_busy_after_rst", 64'(busy), 64'd0);
        rst = 1'b0;
        x0 = n_xfer;
        start_frame(8'd0);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (char_valid) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("s5_restart_valid", 64'(hit), 64'd1);
        check("s5_restart_pos", 64'({char_row, char_col}), 64'd0);
        wait_done(6000, "s5");
        check("s5_count", 64'(n_xfer - x0), 64'(CELLS));

        // Out-of-range offset falls back to row 0.
        x0 = n_xfer;
        start_frame(8'd200);
        check("s6_model_phys0", 64'(exp_q[0].phys), 64'd0);
        wait_done(6000, "s6");
        check("s6_count", 64'(n_xfer - x0), 64'(CELLS));
        check("s6_addr_line0", 64'(obs_addr[0]), 64'd0);

        // rst and start together: reset wins.
        tick();
        rst       = 1'b1;
        start     = 1'b1;
        first_row = 8'd5;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        tick();
        tick();
        check("s7_busy", 64'(busy), 64'd0);
        check("s7_valid", 64'(char_valid), 64'd0);

        repeat (5) tick();
        $display("final dbg_state=%0d", dbg_state);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
